// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder/subtractor: one shared 16-bit prefix adder
// walks the operands one chunk per cycle, least significant chunk first.

module prefixadder16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] p0;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;

    // Kogge-Stone prefix tree; cin is folded into the bit-0 generate
    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        g[0] = g[0] | (p0[0] & cin);
        gn = g;
        pn = p;
        for (int d = 1; d < 16; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
    end

    assign sum  = p0 ^ {g[14:0], cin};
    assign cout = g[15];
endmodule

module multiword_add_seq #(
    parameter int NCHUNK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*NCHUNK-1:0] a,
    input  logic [16*NCHUNK-1:0] b,
    input  logic                 sub,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*NCHUNK-1:0] s,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 16 * NCHUNK;
    localparam int CW = $clog2(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  s_q;
    logic [W-1:0]  s_d;
    logic [CW-1:0] cnt_q;
    logic          c_q;
    logic          cout_q;
    logic          ovf_q;

    logic [15:0]   a_ch;
    logic [15:0]   b_ch;
    logic [15:0]   sum_ch;
    logic          c_d;

    assign a_ch = a_q[{cnt_q, 4'b0} +: 16];
    assign b_ch = b_q[{cnt_q, 4'b0} +: 16];

    prefixadder16bit u_add (
        .a    (a_ch),
        .b    (b_ch),
        .cin  (c_q),
        .sum  (sum_ch),
        .cout (c_d)
    );

    always_comb begin
        s_d = s_q;
        s_d[{cnt_q, 4'b0} +: 16] = sum_ch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        cnt_q   <= '0;
                        c_q     <= cin ^ sub;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    s_q <= s_d;
                    c_q <= c_d;
                    if (cnt_q == LAST) begin
                        cout_q  <= c_d;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) &
                                   (sum_ch[15] != a_q[W-1]);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with NCHUNK = 4.

module tb_multiword_add_seq;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    multiword_add_seq #(.NCHUNK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        chk({tag, " in_ready"}, W'(in_ready), 64'd1);
        a = v.a; b = v.b; sub = v.sub; cin = v.cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
        end
        chk({tag, " latency"}, W'(cyc), 64'd4);
        chk({tag, " s"}, s, v.s);
        chk({tag, " cout"}, W'(cout), W'(v.cout));
        chk({tag, " ovf"}, W'(ovf), W'(v.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, " idle"}, W'({in_ready, busy, out_valid}), 64'b100);
    endtask

    initial begin
        logic [W-1:0] hs;
        logic         hc;
        logic         ho;

        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h0, 64'd1, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{64'h0, 64'd1, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[5] = '{64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
                    1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
        vecs[8] = '{64'd5, 64'd5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = '1; b = '1; sub = 1'b0; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst flags", W'({in_ready, out_valid, busy}), 64'b100);
        chk("rst s", s, 64'h0);
        chk("rst cout/ovf", W'({cout, ovf}), 64'b00);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i], $sformatf("v%0d", i));

        // Stall in DONE while new operands are offered
        @(negedge clk);
        a = vecs[1].a; b = vecs[1].b; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall ov", W'(out_valid), 64'd1);
        hs = s; hc = cout; ho = ovf;
        chk("stall s0", hs, 64'h0);
        a = 64'd3; b = 64'd4; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall s%0d", k), s, hs);
            chk($sformatf("stall co%0d", k), W'({cout, ovf}), W'({hc, ho}));
            chk($sformatf("stall rdy%0d", k), W'({in_ready, out_valid}),
                64'b01);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        chk("stall exit", W'({in_ready, busy, out_valid}), 64'b100);
        @(posedge clk);
        #1;
        chk("no accept", W'({in_ready, busy}), 64'b10);

        // Reset mid-run at counter = 2
        @(negedge clk);
        a = vecs[1].a; b = vecs[1].b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid rst flags", W'({in_ready, out_valid, busy}), 64'b100);
        chk("mid rst s", s, 64'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("mid rst quiet", W'({out_valid, busy}), 64'b00);
        do_op(vecs[5], "post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have parameter NCHUNK, default 4, giving the number of 16-bit chunks per operand; operand width W = 16*NCHUNK; legal NCHUNK >= 2.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 in_valid  input  1  Operand set presented.
REQ-005 in_ready  output  1  Block can accept an operand set.
REQ-006 a  input  W  Operand A, unsigned or two's complement.
REQ-007 b  input  W  Operand B.
REQ-008 sub  input  1  0 = add, 1 = subtract (A - B).
REQ-009 cin  input  1  Carry-in on add; borrow-in on subtract.
REQ-010 out_valid  output  1  Result on s, cout and ovf is complete.
REQ-011 out_ready  input  1  Consumer accepts the result.
REQ-012 s  output  W  Sum or difference.
REQ-013 cout  output  1  Carry out of bit W-1; on subtract, 1 = no borrow.
REQ-014 ovf  output  1  Signed two's-complement overflow.
REQ-015 busy  output  1  High in any state other than IDLE.

Function
REQ-016 The block SHALL instantiate exactly one prefixadder16bit and time-share it, one 16-bit chunk per cycle, least significant chunk first.
REQ-017 FSM states: IDLE, RUN, DONE; IDLE -> RUN on in_valid & in_ready; RUN -> DONE after chunk NCHUNK-1 is written; DONE -> IDLE on out_ready; no other transitions.
REQ-018 in_ready SHALL be 1 only in IDLE; inputs SHALL be ignored in RUN and DONE.
REQ-019 On acceptance: a, sub and b (inverted when sub = 1) are registered; chunk counter = 0; carry register = cin XOR sub.
REQ-020 Each RUN cycle SHALL apply chunk k of the registered operands plus the carry register to the adder, write the adder sum into s[16k+15:16k], load the adder cout into the carry register, and increment k.
REQ-021 Chunk counter SHALL be ceil(log2(NCHUNK)) bits wide and SHALL never wrap within one operation.
REQ-022 On the final chunk: cout = adder cout; ovf = (A[W-1] == B'[W-1]) & (s[W-1] != A[W-1]), where B' is the registered, possibly inverted, B.
REQ-023 Latency: out_valid SHALL first be high exactly NCHUNK cycles after the acceptance edge.
REQ-024 While out_valid = 1 and out_ready = 0, s, cout and ovf SHALL hold constant.
REQ-025 The DONE -> IDLE cycle SHALL NOT also accept a new operand; minimum initiation interval is NCHUNK + 2 cycles.
REQ-026 During RUN, s SHALL expose partially written chunks; consumers SHALL use s only when out_valid = 1.
REQ-027 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-028 With reset = 1 at a rising edge: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, s = 0, cout = 0, ovf = 0, carry register = 0, counter = 0.
REQ-029 Reset SHALL override all other inputs in the same cycle, including in_valid and out_ready.
REQ-030 Reset asserted in RUN or DONE SHALL discard the operation with no result ever presented.

Verification (NCHUNK = 4)
REQ-031 a = 0x0000_0000_0000_FFFF, b = 1, sub = 0, cin = 0 -> s = 0x0000_0000_0001_0000, cout = 0, ovf = 0, out_valid high 4 cycles after acceptance.
REQ-032 a = 0xFFFF_FFFF_FFFF_FFFF, b = 1, sub = 0, cin = 0 -> s = 0, cout = 1, ovf = 0; carry propagates through all four chunks.
REQ-033 a = 0x7FFF_FFFF_FFFF_FFFF, b = 0, sub = 0, cin = 1 -> s = 0x8000_0000_0000_0000, cout = 0, ovf = 1.
REQ-034 a = 0, b = 1, sub = 1, cin = 0 -> s = 0xFFFF_FFFF_FFFF_FFFF, cout = 0, ovf = 0; same with cin = 1 -> s = 0xFFFF_FFFF_FFFF_FFFE.
REQ-035 out_ready held low for 3 cycles in DONE while in_valid = 1 with new operands -> s, cout and ovf unchanged, in_ready = 0, new operands not taken; IDLE on the cycle after out_ready = 1.
REQ-036 reset pulsed when counter = 2 -> next cycle state = IDLE, out_valid = 0, s = 0, in_ready = 1; a following add of 5 + 7 -> s = 12.
